// File: rtl/ledctrl_pkg.sv
// ---------------------------------------------------------------------------
// ledctrl_pkg
// Shared definitions for the serial-LED output engine:
//   - state_t           : frame sequencer states
//   - DEF_*_CYC         : default bit/latch timing for a 25 MHz system clock
//   - scale_brightness  : global brightness scaling of one colour byte
// ---------------------------------------------------------------------------
package ledctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        LATCH
    } state_t;

    localparam int DEF_TBIT_CYC = 31;
    localparam int DEF_T0H_CYC  = 10;
    localparam int DEF_T1H_CYC  = 20;
    localparam int DEF_TRES_CYC = 7500;

    // Scales by (level+1)/256 so that level 255 passes the byte through
    // unchanged and level 0 forces it to zero; the low byte is truncated.
    function automatic logic [7:0] scale_brightness(input logic [7:0] value,
                                                    input logic [7:0] level);
        logic [15:0] product;
        product = {8'd0, value} * ({8'd0, level} + 16'd1);
        return product[15:8];
    endfunction

endpackage

// File: rtl/ledbit_encoder.sv
// ---------------------------------------------------------------------------
// ledbit_encoder
// One-wire NRZ pulse-width coder for a single LED string. The caller owns
// the bit-period phase counter; this block only decides whether the line is
// high at the current phase.
//   phase   in   PH_W  position inside the current bit period (0 = start)
//   bit_val in   1     data bit being transmitted
//   pulse   out  1     line level for this phase (combinational)
// ---------------------------------------------------------------------------
module ledbit_encoder
    import ledctrl_pkg::*;
#(
    parameter int PH_W    = 5,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC
) (
    input  logic [PH_W-1:0] phase,
    input  logic            bit_val,
    output logic            pulse
);

    // The line is high from the start of the period for the bit's high time.
    always_comb begin
        pulse = (32'(phase) < (bit_val ? T1H_CYC : T0H_CYC));
    end

endmodule

// File: rtl/ledstrip_serializer.sv
// ---------------------------------------------------------------------------
// ledstrip_serializer
// Multi-channel WS2812-class output engine. Each channel has its own byte
// buffer; on start all channels are streamed bit-synchronously, with global
// brightness scaling, followed by a low latch gap.
//   clk, reset     clock and asynchronous active-high reset
//   wr_en_i        buffer write strobe (accepted in every state)
//   wr_ch_i        channel to write
//   wr_addr_i      byte address inside the channel buffer
//   wr_data_i      byte to store
//   led_cnt_i      LEDs per channel for the next frame (clamped to MAX_LEDS)
//   brightness_i   global brightness, latched at start
//   start_i        frame request, honoured only in IDLE with led_cnt_i != 0
//   busy_o         high from the cycle after start until the latch gap ends
//   done_o         one-cycle pulse as busy_o falls
//   led_o          serial data, one bit per string
// ---------------------------------------------------------------------------
module ledstrip_serializer
    import ledctrl_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int MAX_LEDS      = 64,
    parameter int BYTES_PER_LED = 3,
    parameter int TBIT_CYC      = DEF_TBIT_CYC,
    parameter int T0H_CYC       = DEF_T0H_CYC,
    parameter int T1H_CYC       = DEF_T1H_CYC,
    parameter int TRES_CYC      = DEF_TRES_CYC
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               wr_en_i,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch_i,
    input  logic [$clog2(MAX_LEDS*BYTES_PER_LED)-1:0]          wr_addr_i,
    input  logic [7:0]                                         wr_data_i,
    input  logic [$clog2(MAX_LEDS+1)-1:0]                      led_cnt_i,
    input  logic [7:0]                                         brightness_i,
    input  logic                                               start_i,
    output logic                                               busy_o,
    output logic                                               done_o,
    output logic [CHANNELS-1:0]                                led_o
);

    localparam int DEPTH  = MAX_LEDS * BYTES_PER_LED;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BYTE_W = $clog2(DEPTH + 1);
    localparam int PH_W   = $clog2(TBIT_CYC);
    localparam int LAT_W  = $clog2(TRES_CYC + 1);

    if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
        $error("ledstrip_serializer: need T0H_CYC < T1H_CYC < TBIT_CYC");
    end
    if (BYTES_PER_LED != 3 && BYTES_PER_LED != 4) begin : g_bad_bpl
        $error("ledstrip_serializer: BYTES_PER_LED must be 3 or 4");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("ledstrip_serializer: CHANNELS must be at least 1");
    end

    state_t                     state;
    logic                       fetch_ph;
    logic [PH_W-1:0]            phase;
    logic [2:0]                 bit_cnt;
    logic [BYTE_W-1:0]          byte_cnt;
    logic [BYTE_W-1:0]          n_bytes;
    logic [BYTE_W-1:0]          n_bytes_next;
    logic [BYTE_W-1:0]          rd_addr;
    logic [LAT_W-1:0]           lat_cnt;
    logic [7:0]                 bright;
    logic [CHANNELS-1:0][7:0]   shift_reg;
    logic [CHANNELS-1:0][7:0]   scaled;
    logic [CHANNELS-1:0]        pulse;
    int                         led_total;

    // Frame length in bytes for the LED count on the inputs, clamped to
    // what the buffer can hold.
    always_comb begin
        led_total = 32'(led_cnt_i);
        if (led_total > MAX_LEDS) begin
            led_total = MAX_LEDS;
        end
        n_bytes_next = BYTE_W'(led_total * BYTES_PER_LED);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_data;

        // Per-channel buffer. The read port follows the shared address every
        // cycle, so a byte is captured only when it is loaded into the shift
        // register and late host writes still land in the current frame.
        always_ff @(posedge clk) begin
            if (wr_en_i && 32'(wr_ch_i) == c && 32'(wr_addr_i) < DEPTH) begin
                mem[wr_addr_i] <= wr_data_i;
            end
            if (32'(rd_addr) < DEPTH) begin
                rd_data <= mem[rd_addr[ADDR_W-1:0]];
            end
        end

        assign scaled[c] = scale_brightness(rd_data, bright);

        ledbit_encoder #(
            .PH_W    (PH_W),
            .T0H_CYC (T0H_CYC),
            .T1H_CYC (T1H_CYC)
        ) u_enc (
            .phase   (phase),
            .bit_val (shift_reg[c][7]),
            .pulse   (pulse[c])
        );
    end

    // Frame sequencer. FETCH spends one cycle issuing address 0 and one
    // loading the scaled byte; SEND walks phase/bit/byte counters shared by
    // all channels, reloading the shift registers from the prefetched read
    // data at each byte boundary; LATCH holds the lines low for TRES_CYC
    // cycles after the final bit period before signalling done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            led_o     <= '0;
            fetch_ph  <= 1'b0;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            n_bytes   <= '0;
            rd_addr   <= '0;
            lat_cnt   <= '0;
            bright    <= '0;
            shift_reg <= '0;
        end else begin
            done_o <= 1'b0;
            led_o  <= '0;
            case (state)
                IDLE: begin
                    if (start_i && led_cnt_i != '0) begin
                        state    <= FETCH;
                        busy_o   <= 1'b1;
                        n_bytes  <= n_bytes_next;
                        bright   <= brightness_i;
                        rd_addr  <= '0;
                        fetch_ph <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        shift_reg <= scaled;
                        rd_addr   <= BYTE_W'(1);
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                        phase     <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    led_o <= pulse;
                    if (phase == PH_W'(TBIT_CYC - 1)) begin
                        phase <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (byte_cnt == n_bytes - BYTE_W'(1)) begin
                                state   <= LATCH;
                                lat_cnt <= '0;
                            end else begin
                                byte_cnt  <= byte_cnt + BYTE_W'(1);
                                rd_addr   <= rd_addr + BYTE_W'(1);
                                shift_reg <= scaled;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            for (int c = 0; c < CHANNELS; c++) begin
                                shift_reg[c] <= {shift_reg[c][6:0], 1'b0};
                            end
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_W'(TRES_CYC)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ledstrip_serializer.sv
// ---------------------------------------------------------------------------
// tb_ledstrip_serializer
// Directed bench for ledstrip_serializer: 4 channels, RGB, 31-cycle bits,
// shortened 200-cycle latch gap. Each frame is decoded from the pulse widths
// on every string and compared with hand-computed byte values.
// ---------------------------------------------------------------------------
module tb_ledstrip_serializer;

    localparam int TBIT = 31;
    localparam int TRES = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] led_cnt;
    logic [7:0] brightness;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;

    logic [7:0] dec [4][192];
    int         w0  [8];

    ledstrip_serializer #(
        .CHANNELS      (4),
        .MAX_LEDS      (64),
        .BYTES_PER_LED (3),
        .TBIT_CYC      (TBIT),
        .T0H_CYC       (10),
        .T1H_CYC       (20),
        .TRES_CYC      (TRES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (wr_en),
        .wr_ch_i      (wr_ch),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .led_cnt_i    (led_cnt),
        .brightness_i (brightness),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .led_o        (led)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input int ch, input int addr, input logic [7:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_addr = 8'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Starts a frame and decodes it. ev_kind 1 pulses start at sample
    // ev_sample, ev_kind 2 writes ev_data to ch0 byte ev_addr at that sample.
    task automatic apply_stimulus(input int nbytes, input int cnt, input int br,
                                  input int ev_sample, input int ev_kind,
                                  input int ev_addr, input int ev_data);
        int hi [4];
        int rise_bad, fall_bad, width_bad, busy_bad, latch_bad;
        int byte_i, bit_i, ph;
        rise_bad = 0; fall_bad = 0; width_bad = 0; busy_bad = 0; latch_bad = 0;
        @(negedge clk);
        led_cnt    = 7'(cnt);
        brightness = 8'(br);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", {63'd0, busy}, 64'd1);
        repeat (2) @(negedge clk);
        for (int s = 0; s < nbytes * 8 * TBIT; s++) begin
            @(negedge clk);
            if (s == ev_sample) begin
                if (ev_kind == 1) begin
                    start = 1'b1;
                end else if (ev_kind == 2) begin
                    wr_en   = 1'b1;
                    wr_ch   = 2'd0;
                    wr_addr = 8'(ev_addr);
                    wr_data = 8'(ev_data);
                end
            end else if (s == ev_sample + 1) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            byte_i = s / (8 * TBIT);
            bit_i  = (s / TBIT) % 8;
            ph     = s % TBIT;
            if (!busy) busy_bad++;
            for (int c = 0; c < 4; c++) begin
                if (ph == 0) begin
                    hi[c] = 0;
                    if (!led[c]) rise_bad++;
                end
                if (led[c]) hi[c]++;
                if (ph == TBIT - 1) begin
                    if (led[c]) fall_bad++;
                    if (hi[c] != 10 && hi[c] != 20) width_bad++;
                    dec[c][byte_i] = {dec[c][byte_i][6:0], (hi[c] == 20)};
                    if (c == 0 && byte_i == 0) w0[bit_i] = hi[c];
                end
            end
        end
        for (int t = 0; t < TRES; t++) begin
            @(negedge clk);
            if (led != 4'd0 || done || !busy) latch_bad++;
        end
        @(negedge clk);
        check_output("done_pulse", {63'd0, done}, 64'd1);
        check_output("busy_fall", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check_output("done_one_cycle", {63'd0, done}, 64'd0);
        check_output("rise_aligned", 64'(rise_bad), 64'd0);
        check_output("fall_in_period", 64'(fall_bad), 64'd0);
        check_output("pulse_widths", 64'(width_bad), 64'd0);
        check_output("busy_in_frame", 64'(busy_bad), 64'd0);
        check_output("latch_gap_low", 64'(latch_bad), 64'd0);
    endtask

    initial begin
        logic [7:0] t1_data [9];
        int         t1_w    [8];
        logic [7:0] t3_data [4];
        logic [7:0] t6_exp  [6];
        int         quiet;

        t1_data = '{8'hAB, 8'h36, 8'h84, 8'hD0, 8'h25, 8'h5A, 8'h00, 8'h77, 8'h0D};
        t1_w    = '{20, 10, 20, 10, 20, 10, 20, 20};
        t3_data = '{8'h11, 8'h22, 8'h44, 8'h88};
        t6_exp  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC3};

        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        led_cnt = '0; brightness = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_led", 64'(led), 64'd0);
        check_output("reset_busy", {63'd0, busy}, 64'd0);
        check_output("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;

        $display("[TB] test 1: 3 RGB LEDs at full brightness");
        for (int i = 0; i < 9; i++) write_byte(0, i, t1_data[i]);
        apply_stimulus(9, 3, 255, -1, 0, 0, 0);
        for (int i = 0; i < 9; i++) check_output($sformatf("t1_byte%0d", i), 64'(dec[0][i]), 64'(t1_data[i]));
        for (int i = 0; i < 8; i++) check_output($sformatf("t1_width%0d", i), 64'(w0[i]), 64'(t1_w[i]));

        $display("[TB] test 2: brightness 127 and 0");
        for (int i = 0; i < 3; i++) begin
            write_byte(0, i, 8'hFF);
            write_byte(1, i, 8'h80);
        end
        apply_stimulus(3, 1, 127, -1, 0, 0, 0);
        check_output("t2_ch0_scaled", 64'(dec[0][0]), 64'h7F);
        check_output("t2_ch1_scaled", 64'(dec[1][0]), 64'h40);
        check_output("t2_ch0_byte2", 64'(dec[0][2]), 64'h7F);
        apply_stimulus(3, 1, 0, -1, 0, 0, 0);
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 3; i++)
                check_output($sformatf("t2_zero_ch%0d_b%0d", c, i), 64'(dec[c][i]), 64'd0);

        $display("[TB] test 3: four strings in parallel");
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 3; i++) write_byte(c, i, t3_data[c]);
        apply_stimulus(3, 1, 255, -1, 0, 0, 0);
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 3; i++)
                check_output($sformatf("t3_ch%0d_b%0d", c, i), 64'(dec[c][i]), 64'(t3_data[c]));

        $display("[TB] test 4: zero count, clamping, start while busy");
        @(negedge clk);
        led_cnt = 7'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) quiet++;
        end
        check_output("t4_cnt0_ignored", 64'(quiet), 64'd0);
        // 200 does not fit the 7-bit count port; it arrives as 72, still above 64.
        apply_stimulus(192, 200 % 128, 255, 1000, 1, 0, 0);
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done || led != 4'd0) quiet++;
        end
        check_output("t4_no_second_frame", 64'(quiet), 64'd0);

        $display("[TB] test 5: asynchronous reset mid-bit");
        @(negedge clk);
        led_cnt = 7'd1; brightness = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        repeat (6) @(negedge clk);
        check_output("t5_led_high", {63'd0, led[0]}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check_output("t5_led_async_low", 64'(led), 64'd0);
        check_output("t5_busy_async_low", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check_output("t5_no_done", {63'd0, done}, 64'd0);
        apply_stimulus(3, 1, 255, -1, 0, 0, 0);
        for (int c = 0; c < 4; c++)
            check_output($sformatf("t5_ch%0d_kept", c), 64'(dec[c][0]), 64'(t3_data[c]));

        $display("[TB] test 6: write during frame, out-of-range write");
        for (int i = 0; i < 6; i++) write_byte(0, i, 8'(i + 1));
        write_byte(0, 192, 8'hEE);
        apply_stimulus(6, 2, 255, 8 * TBIT + 40, 2, 5, 8'hC3);
        for (int i = 0; i < 6; i++) check_output($sformatf("t6_byte%0d", i), 64'(dec[0][i]), 64'(t6_exp[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
